// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared definitions for the burst SRAM controller: FSM state encoding,
//   default interface widths, the legal range of the wait-state parameters
//   and a helper that folds a wait parameter into the counter width.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF  = 19;
  localparam int DATA_W_DEF  = 8;
  localparam int BURST_W_DEF = 4;
  localparam int RD_WAIT_DEF = 1;
  localparam int WR_WAIT_DEF = 1;

  // Wait states are limited to 0..15, so a 4-bit down-counter covers them.
  localparam int WAIT_MAX   = 15;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACCESS = 3'd1,
    WR_SETUP  = 3'd2,
    WR_PULSE  = 3'd3,
    WR_HOLD   = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Out-of-range wait parameters are clamped rather than silently wrapped.
  function automatic logic [WAIT_CNT_W-1:0] clamp_wait(input int w);
    if (w < 0)
      return '0;
    else if (w > WAIT_MAX)
      return WAIT_CNT_W'(WAIT_MAX);
    else
      return WAIT_CNT_W'(w);
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt
//   Loadable down-counter that times the access phases of one SRAM beat.
//   It stops at zero; zero is high whenever the count is zero.
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset (count cleared)
//   load      load load_val this cycle (takes priority over counting)
//   load_val  value to load
//   zero      count == 0
module sram_wait_cnt
  import sram_ctrl_pkg::*;
#(
  parameter int CNT_W = WAIT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl_burst.sv
// sram_ctrl_burst
//   Burst controller for an asynchronous SRAM with active-low CE/OE/WE.
//   A request accepted in IDLE performs burst_len+1 beats at consecutive
//   (wrapping) addresses, either reads (RD_WAIT+1 cycles per beat, OE held
//   low across the burst) or writes (setup / WE pulse of WR_WAIT+1 cycles /
//   hold, WR_WAIT+3 cycles per beat), then spends one cycle in DONE.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start_operation, rw             request strobe, 1 = read / 0 = write
//   address_input, burst_len        start address, beats-1
//   data_f2s / data_f2s_req         write word in / request for next word
//   data_s2f                        registered read word
//   data_ready_signal_output        one-cycle strobe per read beat
//   writing_finished_signal_output  one-cycle strobe in DONE of a write
//   busy_signal_output              high outside IDLE
//   address_to_sram_output          SRAM address
//   we/oe/ce_to_sram_output         SRAM controls, active-low
//   data_from_to_sram_input_output  bidirectional SRAM data bus
module sram_ctrl_burst
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_operation,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address_input,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0] data_f2s,
  output logic              data_f2s_req,
  output logic [DATA_W-1:0] data_s2f,
  output logic              data_ready_signal_output,
  output logic              writing_finished_signal_output,
  output logic              busy_signal_output,
  output logic [ADDR_W-1:0] address_to_sram_output,
  output logic              we_to_sram_output,
  output logic              oe_to_sram_output,
  output logic              ce_to_sram_output,
  inout  wire  [DATA_W-1:0] data_from_to_sram_input_output
);

  localparam logic [WAIT_CNT_W-1:0] RD_WAIT_L = clamp_wait(RD_WAIT);
  localparam logic [WAIT_CNT_W-1:0] WR_WAIT_L = clamp_wait(WR_WAIT);

  state_t               state;
  state_t               state_nxt;
  logic [BURST_W-1:0]   beats_left;
  logic [ADDR_W-1:0]    addr_r;
  logic [DATA_W-1:0]    wr_word;
  logic                 is_read;
  logic                 rd_strobe;
  logic                 bus_en;

  logic                 wait_load;
  logic [WAIT_CNT_W-1:0] wait_val;
  logic                 wait_zero;

  logic                 start_acc;
  logic                 last_beat;
  logic                 rd_beat_end;
  logic                 wr_beat_end;
  logic                 advance;

  assign start_acc   = (state == IDLE) && start_operation;
  assign last_beat   = (beats_left == '0);
  assign rd_beat_end = (state == RD_ACCESS) && wait_zero;
  assign wr_beat_end = (state == WR_HOLD);
  assign advance     = (rd_beat_end || wr_beat_end) && !last_beat;

  // Reads load the counter on entry to every beat; writes load it in
  // WR_SETUP so that it times only the WE pulse.
  assign wait_load = (start_acc && rw) || (rd_beat_end && !last_beat) ||
                     (state == WR_SETUP);
  assign wait_val  = (state == WR_SETUP) ? WR_WAIT_L : RD_WAIT_L;

  sram_wait_cnt #(
    .CNT_W    (WAIT_CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wait_load),
    .load_val (wait_val),
    .zero     (wait_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_operation)
          state_nxt = rw ? RD_ACCESS : WR_SETUP;
      end
      RD_ACCESS: begin
        if (wait_zero && last_beat)
          state_nxt = DONE;
      end
      WR_SETUP:  state_nxt = WR_PULSE;
      WR_PULSE: begin
        if (wait_zero)
          state_nxt = WR_HOLD;
      end
      WR_HOLD:   state_nxt = last_beat ? DONE : WR_SETUP;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode; follows the state register so reset acts immediately.
  always_comb begin
    ce_to_sram_output              = 1'b1;
    oe_to_sram_output              = 1'b1;
    we_to_sram_output              = 1'b1;
    bus_en                         = 1'b0;
    busy_signal_output             = 1'b1;
    data_f2s_req                   = 1'b0;
    writing_finished_signal_output = 1'b0;
    case (state)
      IDLE: busy_signal_output = 1'b0;
      RD_ACCESS: begin
        ce_to_sram_output = 1'b0;
        oe_to_sram_output = 1'b0;
      end
      WR_SETUP: begin
        ce_to_sram_output = 1'b0;
        bus_en            = 1'b1;
        data_f2s_req      = !last_beat;
      end
      WR_PULSE: begin
        ce_to_sram_output = 1'b0;
        we_to_sram_output = 1'b0;
        bus_en            = 1'b1;
      end
      WR_HOLD: begin
        ce_to_sram_output = 1'b0;
        bus_en            = 1'b1;
      end
      DONE: writing_finished_signal_output = !is_read;
      default: busy_signal_output = 1'b0;
    endcase
  end

  // Burst bookkeeping and read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_left <= '0;
      addr_r     <= '0;
      is_read    <= 1'b0;
      rd_strobe  <= 1'b0;
      data_s2f   <= '0;
    end else begin
      rd_strobe <= rd_beat_end;
      if (rd_beat_end)
        data_s2f <= data_from_to_sram_input_output;
      if (start_acc) begin
        beats_left <= burst_len;
        addr_r     <= address_input;
        is_read    <= rw;
      end else if (advance) begin
        beats_left <= beats_left - 1'b1;
        addr_r     <= addr_r + 1'b1;
      end
    end
  end

  // Write word: first word with the request, later words at the end of the
  // previous beat's hold cycle.
  always_ff @(posedge clk) begin
    if ((start_acc && !rw) || (wr_beat_end && !last_beat))
      wr_word <= data_f2s;
  end

  assign data_ready_signal_output       = rd_strobe;
  assign address_to_sram_output         = addr_r;
  assign data_from_to_sram_input_output = bus_en ? wr_word : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_burst.sv
// tb_sram_ctrl_burst
//   Two controller instances (default timing, and RD_WAIT=3/WR_WAIT=2) with a
//   behavioural SRAM that returns a pattern derived from the address.
//   Expected pin activity per cycle is computed from the beat timing rules:
//   cycle c counts clock periods after the edge that accepted the request.
module tb_sram_ctrl_burst;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_op [2];
  logic          rw_i     [2];
  logic [AW-1:0] addr_in  [2];
  logic [BW-1:0] blen     [2];
  logic [DW-1:0] f2s      [2];
  logic          req      [2];
  logic [DW-1:0] s2f      [2];
  logic          rdy      [2];
  logic          fin      [2];
  logic          busy     [2];
  logic [AW-1:0] sa       [2];
  logic          we       [2];
  logic          oe       [2];
  logic          ce       [2];
  logic [DW-1:0] bus_obs  [2];

  bit            fixed_pat;
  logic [7:0]    seed [2];
  logic [DW-1:0] wwords [16];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] sram_word(input bit fx, input logic [7:0] sd,
                                           input logic [AW-1:0] ad);
    if (fx)
      return 8'hA5;
    return ad[7:0] ^ ad[15:8] ^ {5'b0, ad[18:16]} ^ sd;
  endfunction

  function automatic int rd_wait_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int wr_wait_of(input int g);
    return (g == 0) ? 1 : 2;
  endfunction

  genvar gv;
  generate
    for (gv = 0; gv < 2; gv++) begin : gi
      wire [DW-1:0] bus;
      assign bus = (!oe[gv] && !ce[gv]) ? sram_word(fixed_pat, seed[gv], sa[gv])
                                        : {DW{1'bz}};
      assign bus_obs[gv] = bus;

      sram_ctrl_burst #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RD_WAIT ((gv == 0) ? 1 : 3),
        .WR_WAIT ((gv == 0) ? 1 : 2),
        .BURST_W (BW)
      ) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .start_operation                (start_op[gv]),
        .rw                             (rw_i[gv]),
        .address_input                  (addr_in[gv]),
        .burst_len                      (blen[gv]),
        .data_f2s                       (f2s[gv]),
        .data_f2s_req                   (req[gv]),
        .data_s2f                       (s2f[gv]),
        .data_ready_signal_output       (rdy[gv]),
        .writing_finished_signal_output (fin[gv]),
        .busy_signal_output             (busy[gv]),
        .address_to_sram_output         (sa[gv]),
        .we_to_sram_output              (we[gv]),
        .oe_to_sram_output              (oe[gv]),
        .ce_to_sram_output              (ce[gv]),
        .data_from_to_sram_input_output (bus)
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One transaction on instance g. Control vector is {busy,ce,oe,we,rdy,req,fin}.
  // abort_at >= 0 asserts reset in that cycle and ends the transaction there.
  task automatic run_txn(input int g, input bit rd, input logic [AW-1:0] a,
                         input logic [BW-1:0] bl, input bit hold_start,
                         input int abort_at);
    int n, per, total, b, ph, wt;
    logic [AW-1:0] ea;
    logic [6:0] ctl_e, ctl_o;
    wt    = rd ? rd_wait_of(g) : wr_wait_of(g);
    n     = int'(bl) + 1;
    per   = rd ? wt + 1 : wt + 3;
    total = n * per;

    @(negedge clk);
    rw_i[g]     = rd;
    addr_in[g]  = a;
    blen[g]     = bl;
    f2s[g]      = wwords[0];
    start_op[g] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start_op[g] = 1'b0;
    rw_i[g]    = 1'($urandom);
    addr_in[g] = AW'($urandom);
    blen[g]    = BW'($urandom);

    for (int c = 0; c <= total + 2; c++) begin
      @(negedge clk);
      b  = c / per;
      ph = c % per;
      if (!rd && c < total && ph == per - 1 && b < n - 1)
        f2s[g] = wwords[b + 1];
      else
        f2s[g] = DW'($urandom);
      if (c == total) start_op[g] = 1'b0;

      ea = a + AW'(b);
      if (c > total)
        ctl_e = 7'b0111000;
      else if (c == total)
        ctl_e = {1'b1, 3'b111, rd, 1'b0, !rd};
      else if (rd)
        ctl_e = {1'b1, 1'b0, 1'b0, 1'b1, (c >= per && ph == 0), 1'b0, 1'b0};
      else
        ctl_e = {1'b1, 1'b0, 1'b1, !(ph >= 1 && ph <= wt + 1), 1'b0,
                 (ph == 0 && b < n - 1), 1'b0};
      ctl_o = {busy[g], ce[g], oe[g], we[g], rdy[g], req[g], fin[g]};
      check($sformatf("ctl g%0d rd%0d c%0d", g, rd, c), 32'(ctl_o), 32'(ctl_e));

      if (c < total) begin
        check($sformatf("addr g%0d c%0d", g, c), 32'(sa[g]), 32'(ea));
        if (rd)
          check($sformatf("rbus g%0d c%0d", g, c), 32'(bus_obs[g]),
                32'(sram_word(fixed_pat, seed[g], ea)));
        else
          check($sformatf("wbus g%0d c%0d", g, c), 32'(bus_obs[g]), 32'(wwords[b]));
      end
      if (rd && c >= per && ph == 0 && c <= total)
        check($sformatf("rdata g%0d c%0d", g, c), 32'(s2f[g]),
              32'(sram_word(fixed_pat, seed[g], a + AW'(b - 1))));

      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst ctl", 32'({busy[g], ce[g], oe[g], we[g], rdy[g], req[g], fin[g]}),
              32'(7'b0111000));
        check("rst addr", 32'(sa[g]), 32'h0);
        check("rst s2f", 32'(s2f[g]), 32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        start_op[g] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check($sformatf("post-rst idle k%0d", k),
                32'({busy[g], ce[g], oe[g], we[g], rdy[g], req[g], fin[g]}),
                32'(7'b0111000));
        end
        return;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    fixed_pat = 1'b1;
    seed[0]   = 8'h3C;
    seed[1]   = 8'hC3;
    for (int g = 0; g < 2; g++) begin
      start_op[g] = 1'b0;
      rw_i[g]     = 1'b0;
      addr_in[g]  = '0;
      blen[g]     = '0;
      f2s[g]      = '0;
    end
    for (int i = 0; i < 16; i++) wwords[i] = '0;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset ctl g%0d", g),
            32'({busy[g], ce[g], oe[g], we[g], rdy[g], req[g], fin[g]}), 32'(7'b0111000));
      check($sformatf("reset addr g%0d", g), 32'(sa[g]), 32'h0);
      check($sformatf("reset s2f g%0d", g), 32'(s2f[g]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat read, SRAM returns 0xA5.
    run_txn(0, 1'b1, 19'h00010, 4'd0, 1'b0, -1);

    // Four-beat write across the top of the address space.
    fixed_pat = 1'b0;
    wwords[0] = 8'h11; wwords[1] = 8'h22; wwords[2] = 8'h33; wwords[3] = 8'h44;
    run_txn(0, 1'b0, 19'h7FFFE, 4'd3, 1'b0, -1);

    // Three-beat read with RD_WAIT=3.
    run_txn(1, 1'b1, 19'h00100, 4'd2, 1'b0, -1);

    // start_operation held high through a write burst.
    for (int i = 0; i < 16; i++) wwords[i] = DW'($urandom);
    run_txn(0, 1'b0, 19'h12345, 4'd2, 1'b1, -1);

    // Reset during the WE pulse of beat 1, then normal operation.
    run_txn(0, 1'b0, 19'h00200, 4'd3, 1'b0, wr_wait_of(0) + 3 + 1);
    run_txn(0, 1'b0, 19'h00300, 4'd1, 1'b0, -1);
    run_txn(0, 1'b1, 19'h00300, 4'd1, 1'b0, -1);

    // Maximum-length bursts wrapping the address.
    for (int i = 0; i < 16; i++) wwords[i] = DW'($urandom);
    run_txn(1, 1'b0, 19'h7FFF8, 4'hF, 1'b0, -1);
    run_txn(0, 1'b1, 19'h7FFF4, 4'hF, 1'b0, -1);

    // Randomized transactions.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) wwords[i] = DW'($urandom);
      seed[0] = 8'($urandom);
      seed[1] = 8'($urandom);
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), AW'($urandom),
              BW'($urandom), 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
